// File: rtl/ov_cfg_pkg.sv
// Shared types and constants for the OV camera configuration sequencer.
package ov_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RST_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SWRST_ADDR = 8'h12;
    localparam int         SWRST_BIT  = 7;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    // A write of COM7 with bit 7 set resets the sensor and wipes its registers.
    function automatic logic is_swrst(cfg_entry_t e);
        return (e.addr == SWRST_ADDR) && e.data[SWRST_BIT];
    endfunction

    function automatic int max_of(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov_cfg_rom.sv
// Fixed sensor register table; combinational index -> {addr, data} lookup.
module ov_cfg_rom
    import ov_cfg_pkg::*;
#(
    parameter int REG_NUM = 8
) (
    input  logic [7:0]  idx,
    output logic [15:0] entry
);

    cfg_entry_t e;

    always_comb begin
        // NOTE: default assigned first so every path drives e and no latch is inferred.
        e = '{addr: 8'hFF, data: 8'hFF};
        if (int'(idx) < REG_NUM) begin
            case (idx)
                8'd0:    e = '{addr: 8'h12, data: 8'h80};
                8'd1:    e = '{addr: 8'h11, data: 8'h01};
                8'd2:    e = '{addr: 8'h12, data: 8'h14};
                8'd3:    e = '{addr: 8'h0C, data: 8'h04};
                8'd4:    e = '{addr: 8'h3E, data: 8'h00};
                8'd5:    e = '{addr: 8'h70, data: 8'h3A};
                8'd6:    e = '{addr: 8'h71, data: 8'h35};
                8'd7:    e = '{addr: 8'h72, data: 8'h11};
                default: e = '{addr: 8'hFF, data: 8'hFF};
            endcase
        end
    end

    assign entry = e;

endmodule

// File: rtl/ov_cfg_seq.sv
// Walks the sensor register table, writing each entry over SCCB and
// optionally reading it back, then reports done or the first failing index.
module ov_cfg_seq
    import ov_cfg_pkg::*;
#(
    parameter int REG_NUM   = 8,
    parameter int DLY_PWRUP = 1_000_000,
    parameter int DLY_SWRST = 50_000,
    parameter int GAP       = 500,
    parameter int TIMEOUT   = 4096,
    parameter int VERIFY    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    input  logic       rd_vld,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] err_idx
);

    localparam int CNT_MAX = max_of(max_of(DLY_PWRUP, DLY_SWRST), max_of(GAP, TIMEOUT));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(DLY_PWRUP - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(DLY_SWRST - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       IDX_LAST = 8'(REG_NUM - 1);

    state_t           state;
    logic [7:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rom_idx;
    logic [15:0]      rom_entry;
    cfg_entry_t       rom_e;

    // The next entry is loaded while leaving GAP, so look one index ahead there.
    assign rom_idx = (state == ST_GAP) ? idx + 8'd1 : idx;
    assign rom_e   = cfg_entry_t'(rom_entry);

    ov_cfg_rom #(.REG_NUM(REG_NUM)) u_rom (
        .idx   (rom_idx),
        .entry (rom_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_en    <= 1'b0;
            busy     <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_idx  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register updates from pre-edge values.
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_PWR_WAIT;
                        idx      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        err_idx  <= '0;
                    end
                end
                ST_PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        cnt     <= '0;
                        state   <= ST_WR_REQ;
                        wr_en   <= 1'b1;
                        wr_addr <= rom_e.addr;
                        wr_data <= rom_e.data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    state <= ST_WR_WAIT;
                    cnt   <= '0;
                end
                ST_WR_WAIT: begin
                    // A pulse landing on the final count still counts as in time.
                    if (wr_done) begin
                        cnt <= '0;
                        if (is_swrst(cfg_entry_t'({wr_addr, wr_data}))) begin
                            state <= ST_RST_WAIT;
                        end else if (VERIFY != 0) begin
                            state <= ST_RD_REQ;
                            rd_en <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= ST_ERR;
                        busy    <= 1'b0;
                        cfg_err <= 1'b1;
                        err_idx <= idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt == RST_LAST) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    state <= ST_RD_WAIT;
                    cnt   <= '0;
                end
                ST_RD_WAIT: begin
                    if (rd_vld) begin
                        cnt <= '0;
                        if (rd_data == wr_data) begin
                            state <= ST_GAP;
                        end else begin
                            state   <= ST_ERR;
                            busy    <= 1'b0;
                            cfg_err <= 1'b1;
                            err_idx <= idx;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= ST_ERR;
                        busy    <= 1'b0;
                        cfg_err <= 1'b1;
                        err_idx <= idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            idx     <= idx + 8'd1;
                            state   <= ST_WR_REQ;
                            wr_en   <= 1'b1;
                            wr_addr <= rom_e.addr;
                            wr_data <= rom_e.data;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_cfg_seq.sv
// Self-checking bench: SCCB engine responder, transaction monitor and a
// table-walk model predicting every request, its cycle, and the final status.
module tb_ov_cfg_seq;

    localparam int REG_NUM   = 3;
    localparam int DLY_PWRUP = 10;
    localparam int DLY_SWRST = 20;
    localparam int GAP       = 4;
    localparam int TIMEOUT   = 64;
    localparam int WAIT_MAX  = 5000;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_inj = 1'b0;
    logic sel = 1'b0;
    logic wr_done = 1'b0;
    logic rd_vld = 1'b0;
    logic [7:0] rd_data = 8'h00;

    logic a_wr_en, a_rd_en, a_busy, a_done, a_err;
    logic [7:0] a_addr, a_data, a_idx;
    logic b_wr_en, b_rd_en, b_busy, b_done, b_err;
    logic [7:0] b_addr, b_data, b_idx;
    logic start_a, start_b;
    logic m_wr_en, m_rd_en, m_busy, m_done, m_err;
    logic [7:0] m_addr, m_data, m_idx;

    assign start_a = (start | start_inj) & ~sel;
    assign start_b = (start | start_inj) & sel;

    ov_cfg_seq #(.REG_NUM(REG_NUM), .DLY_PWRUP(DLY_PWRUP), .DLY_SWRST(DLY_SWRST),
                 .GAP(GAP), .TIMEOUT(TIMEOUT), .VERIFY(1)) u_dut_v (
        .clk(clk), .rst_n(rst_n), .start(start_a), .wr_en(a_wr_en), .wr_addr(a_addr),
        .wr_data(a_data), .wr_done(wr_done), .rd_en(a_rd_en), .rd_data(rd_data),
        .rd_vld(rd_vld), .busy(a_busy), .cfg_done(a_done), .cfg_err(a_err), .err_idx(a_idx));

    ov_cfg_seq #(.REG_NUM(REG_NUM), .DLY_PWRUP(DLY_PWRUP), .DLY_SWRST(DLY_SWRST),
                 .GAP(GAP), .TIMEOUT(TIMEOUT), .VERIFY(0)) u_dut_nv (
        .clk(clk), .rst_n(rst_n), .start(start_b), .wr_en(b_wr_en), .wr_addr(b_addr),
        .wr_data(b_data), .wr_done(wr_done), .rd_en(b_rd_en), .rd_data(rd_data),
        .rd_vld(rd_vld), .busy(b_busy), .cfg_done(b_done), .cfg_err(b_err), .err_idx(b_idx));

    assign m_wr_en = sel ? b_wr_en : a_wr_en;
    assign m_rd_en = sel ? b_rd_en : a_rd_en;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_data  = sel ? b_data  : a_data;
    assign m_idx   = sel ? b_idx   : a_idx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder behaviour and stray-pulse injection, set by the test tasks.
    int wr_lat = 30, rd_lat = 40;
    bit wr_resp = 1'b1, bad11 = 1'b0;
    int inj_wr0 = -1, inj_wr1 = -1, inj_rd = -1, inj_st0 = -1, inj_st1 = -1;

    int wcnt = 0, rcnt = 0;
    logic [7:0] rd_addr_q = 8'h00;
    logic [7:0] sensor_mem [256];
    ev_t obs_q [$];

    // Sensor/engine model plus request monitor; acts on the falling edge.
    always @(negedge clk) begin
        wr_done   = 1'b0;
        rd_vld    = 1'b0;
        start_inj = 1'b0;
        if (!rst_n) begin
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) wr_done = 1'b1;
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    rd_vld  = 1'b1;
                    rd_data = (bad11 && rd_addr_q == 8'h11) ? 8'h00 : sensor_mem[rd_addr_q];
                end
            end
            if (m_wr_en) begin
                sensor_mem[m_addr] = m_data;
                obs_q.push_back('{is_rd: 1'b0, cyc: 32'(cyc), addr: m_addr, data: m_data});
                if (wr_resp) wcnt = wr_lat;
            end
            if (m_rd_en) begin
                obs_q.push_back('{is_rd: 1'b1, cyc: 32'(cyc), addr: m_addr, data: 8'h00});
                rd_addr_q = m_addr;
                rcnt = rd_lat;
            end
            if (cyc == inj_wr0 || cyc == inj_wr1) wr_done = 1'b1;
            if (cyc == inj_rd) begin
                rd_vld  = 1'b1;
                rd_data = 8'h5A;
            end
            if (cyc == inj_st0 || cyc == inj_st1) start_inj = 1'b1;
        end
    end

    // Reference model: what a correct sequencer does with this table and responder.
    logic [7:0] tab_addr [REG_NUM] = '{8'h12, 8'h11, 8'h12};
    logic [7:0] tab_data [REG_NUM] = '{8'h80, 8'h01, 8'h14};
    ev_t exp_q [$];
    bit  exp_done, exp_err;
    logic [7:0] exp_idx;
    int  exp_end;

    task automatic build_model(input int c, input bit verify);
        int t, t2, gs;
        logic [7:0] resp;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_idx  = 8'h00;
        t = c + DLY_PWRUP + 1;
        for (int i = 0; i < REG_NUM; i++) begin
            exp_q.push_back('{is_rd: 1'b0, cyc: 32'(t), addr: tab_addr[i], data: tab_data[i]});
            if (!wr_resp || wr_lat > TIMEOUT) begin
                exp_err = 1'b1; exp_idx = 8'(i); exp_end = t + TIMEOUT + 1;
                return;
            end
            t2 = t + wr_lat + 1;
            if (tab_addr[i] == 8'h12 && tab_data[i][7]) begin
                gs = t2 + DLY_SWRST;
            end else if (verify) begin
                exp_q.push_back('{is_rd: 1'b1, cyc: 32'(t2), addr: tab_addr[i], data: 8'h00});
                if (rd_lat > TIMEOUT) begin
                    exp_err = 1'b1; exp_idx = 8'(i); exp_end = t2 + TIMEOUT + 1;
                    return;
                end
                resp = (bad11 && tab_addr[i] == 8'h11) ? 8'h00 : tab_data[i];
                if (resp != tab_data[i]) begin
                    exp_err = 1'b1; exp_idx = 8'(i); exp_end = t2 + rd_lat + 1;
                    return;
                end
                gs = t2 + rd_lat + 1;
            end else begin
                gs = t2;
            end
            t = gs + GAP;
        end
        exp_done = 1'b1;
        exp_end  = t;
    endtask

    int n_checks = 0, n_errors = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int c);
        tick();
        start = 1'b1;
        c = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int end_cyc);
        int n = 0;
        while (m_busy && n < WAIT_MAX) begin
            tick();
            n++;
        end
        end_cyc = cyc;
        n_checks++;
        if (m_busy) begin
            n_errors++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, m_busy, n);
        end
    endtask

    // Scores one run: every observed request against the model, then status and end time.
    task automatic score_run(input string name, input int base, input int end_cyc);
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_errors++;
            $display("FAIL %s/count: got %0d requests, required %0d", name, obs_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i < obs_q.size()) begin
                n_checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL %s/req%0d: got rd=%0b cyc=%0d %h/%h, required rd=%0b cyc=%0d %h/%h",
                             name, i, obs_q[base+i].is_rd, obs_q[base+i].cyc, obs_q[base+i].addr,
                             obs_q[base+i].data, exp_q[i].is_rd, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        n_checks++;
        if ({m_done, m_err, m_idx} !== {exp_done, exp_err, exp_idx}) begin
            n_errors++;
            $display("FAIL %s/status: got done=%0b err=%0b idx=%0d, required done=%0b err=%0b idx=%0d",
                     name, m_done, m_err, m_idx, exp_done, exp_err, exp_idx);
        end
        n_checks++;
        if (end_cyc !== exp_end) begin
            n_errors++;
            $display("FAIL %s/end_cycle: got %0d, required %0d", name, end_cyc, exp_end);
        end
    endtask

    task automatic run_one(input string name, input bit verify, input bit inject);
        int c, base, end_cyc, w0, gap0;
        repeat ($urandom_range(0, 3)) tick();
        base = obs_q.size();
        pulse_start(c);
        build_model(c, verify);
        if (inject) begin
            w0   = c + DLY_PWRUP + 1;
            gap0 = w0 + wr_lat + 1 + DLY_SWRST;
            inj_st0 = c + 5;
            inj_st1 = gap0 + int'($urandom_range(0, GAP - 1));
            inj_wr0 = gap0 + int'($urandom_range(0, GAP - 1));
            inj_wr1 = gap0 + GAP;
            inj_rd  = gap0 + GAP + 5;
        end
        wait_idle(name, end_cyc);
        score_run(name, base, end_cyc);
        inj_st0 = -1; inj_st1 = -1; inj_wr0 = -1; inj_wr1 = -1; inj_rd = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({a_wr_en, a_rd_en, a_busy, a_done, a_err, a_addr, a_data, a_idx,
             b_wr_en, b_rd_en, b_busy, b_done, b_err, b_addr, b_data, b_idx} !== '0) begin
            n_errors++;
            $display("FAIL reset: outputs not all zero (a_busy=%0b a_addr=%h b_busy=%0b b_addr=%h)",
                     a_busy, a_addr, b_busy, b_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        sel = 1'b0; wr_lat = 30; rd_lat = 40; wr_resp = 1'b1; bad11 = 1'b0;
        run_one("basic", 1'b1, 1'b0);
    endtask

    task automatic test_mismatch();
        sel = 1'b0; wr_lat = 30; rd_lat = 40; wr_resp = 1'b1; bad11 = 1'b1;
        run_one("mismatch", 1'b1, 1'b0);
        bad11 = 1'b0;
    endtask

    task automatic test_timeout();
        sel = 1'b0; wr_resp = 1'b0;
        run_one("wr_timeout", 1'b1, 1'b0);
        wr_resp = 1'b1;
    endtask

    task automatic test_verify_off();
        sel = 1'b1; wr_lat = 30; rd_lat = 40;
        run_one("verify_off", 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_ignored_pulses();
        sel = 1'b0; wr_lat = 30; rd_lat = 40;
        run_one("ignored_pulses", 1'b1, 1'b1);
    endtask

    task automatic test_timeout_boundary();
        sel = 1'b0; wr_lat = TIMEOUT; rd_lat = TIMEOUT;
        run_one("pulse_on_last_count", 1'b1, 1'b0);
        wr_lat = 30; rd_lat = TIMEOUT + 1;
        run_one("rd_timeout", 1'b1, 1'b0);
        rd_lat = 40;
    endtask

    task automatic test_mid_reset();
        int c, base, rr, end_cyc;
        sel = 1'b0; wr_lat = 30; rd_lat = 40;
        tick();
        base = obs_q.size();
        pulse_start(c);
        build_model(c, 1'b1);
        rr = int'(exp_q[2].cyc) + int'($urandom_range(2, 30));
        while (cyc < rr) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({m_wr_en, m_rd_en, m_busy, m_done, m_err, m_addr, m_data, m_idx} !== '0) begin
                n_errors++;
                $display("FAIL mid_reset/outputs: busy=%0b wr_en=%0b rd_en=%0b addr=%h, required all 0",
                         m_busy, m_wr_en, m_rd_en, m_addr);
            end
            tick();
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() - base !== 3) begin
            n_errors++;
            $display("FAIL mid_reset/requests: got %0d before restart, required 3", obs_q.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            if (base + i < obs_q.size()) begin
                n_checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL mid_reset/req%0d: got cyc=%0d addr=%h, required cyc=%0d addr=%h",
                             i, obs_q[base+i].cyc, obs_q[base+i].addr, exp_q[i].cyc, exp_q[i].addr);
                end
            end
        end
        run_one("after_reset", 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            sel    = 1'($urandom_range(0, 1));
            wr_lat = int'($urandom_range(1, TIMEOUT + 6));
            rd_lat = int'($urandom_range(1, TIMEOUT + 6));
            bad11  = 1'($urandom_range(0, 1));
            run_one($sformatf("random%0d", k), ~sel, 1'b0);
        end
        sel = 1'b0; bad11 = 1'b0; wr_lat = 30; rd_lat = 40;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_timeout();
        test_verify_off();
        test_ignored_pulses();
        test_timeout_boundary();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
